axi_4_lite_regbank: RTL
=======================

# axi_4_lite_regbank

Parametrised AXI4-Lite slave register bank, the successor to the basic write-only slave. It implements both the write and read channels, accepts AW and W independently, and back-pressures on stalled B/R channels. Per-register read-only protection and address decoding produce SLVERR/DECERR responses. It sits between the AXI4-Lite interconnect and user logic, exposing every register plus per-register write pulses.

## Interface
- C_AXI_DATA_WIDTH, 32: data width; must be 32 or 64. Strobe width C_AXI_DATA_WIDTH/8; ADDR_LSB = log2(C_AXI_DATA_WIDTH/8).
- C_AXI_ADDR_WIDTH, 8: byte address width.
- C_REGISTERS_NUMBER, 16: register count, 1..2^(C_AXI_ADDR_WIDTH-ADDR_LSB).
- C_RO_MASK, 0: bit i set makes register i read-only. Its read value is taken from ro_in.

Ports:
- S_AXI_ACLK  in  1  single clock; all logic is on the rising edge.
- S_AXI_ARESET  in  1  reset, synchronous, active-high.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake.
- S_AXI_AWADDR  in  C_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake.
- S_AXI_WDATA  in  C_AXI_DATA_WIDTH  write data.
- S_AXI_WSTRB  in  C_AXI_DATA_WIDTH/8  byte enables.
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake.
- S_AXI_ARADDR  in  C_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake.
- S_AXI_RDATA  out  C_AXI_DATA_WIDTH  read data.
- S_AXI_RRESP  out  2  read response.
- reg_out  out  C_REGISTERS_NUMBER*C_AXI_DATA_WIDTH  flattened register contents; register i occupies bits [i*W +: W].
- ro_in  in  C_REGISTERS_NUMBER*C_AXI_DATA_WIDTH  read-only sources; only RO slices are used.
- wr_pulse  out  C_REGISTERS_NUMBER  one-cycle pulse per successfully written register.

## Operation
- Index decode: index = ADDR[C_AXI_ADDR_WIDTH-1:ADDR_LSB]. Low bits are ignored, so unaligned addresses hit the containing word.
- Write side: separate one-entry AW hold and W hold.
  - AWREADY = !aw_full and WREADY = !w_full, both gated low while in reset.
  - aw_avail = aw_full | AW handshake this cycle; w_avail likewise.
- Commit condition: aw_avail & w_avail & (!BVALID | BREADY). On commit:
  - index >= C_REGISTERS_NUMBER: BRESP=DECERR (2'b11), no change.
  - RO index: BRESP=SLVERR (2'b10), no change.
  - otherwise: BRESP=OKAY; bytes with WSTRB set are updated. If WSTRB != 0, wr_pulse[index] fires. WSTRB == 0 gives OKAY with no change and no pulse.
  - In all cases BVALID is set and both holds are cleared.
- Handshake arriving with no commit: the channel's hold fills and its READY drops until the commit.
- BVALID is held with stable BRESP until BREADY.
- Read side: ARREADY = !RVALID | RREADY, gated low in reset.
- On AR handshake: RDATA/RRESP are registered and RVALID is set.
  - RW register: current register value, OKAY.
  - RO register: ro_in slice, OKAY.
  - Out of range: RDATA=0, RRESP=DECERR.
- RVALID, RDATA and RRESP are held stable until RREADY.
- Read and write channels are fully independent; they may both handshake in any cycle.

## Timing
- Reset, while S_AXI_ARESET is high and on the first cycle after:
  - AWREADY, WREADY, ARREADY, BVALID, RVALID and wr_pulse are 0; BRESP=0, RRESP=0, RDATA=0.
  - All registers (reg_out) are 0 and both holds are empty.
  - Readies go to 1 on the first cycle with reset low.
- Reset mid-operation: pending holds and responses are dropped; BVALID and RVALID are 0 on the cycle after reset is sampled.
- Write latency: BVALID, register update and wr_pulse appear one cycle after the later of the AW/W handshakes (cycle N+1 for handshakes in cycle N). Holds make no further difference.
- Write throughput: with AW and W presented together and BREADY high, one write per cycle.
- Stalled B: a second AW/W pair is accepted into the holds, then READY drops. The commit occurs in the cycle BREADY is seen with BVALID high, and the new BVALID follows on the next cycle.
- Read latency: RVALID one cycle after the AR handshake. Throughput is one read per cycle with RREADY held high.
- Same-cycle read and commit to the same register: the read returns the pre-write value.
- wr_pulse is high for exactly one cycle, aligned with the first cycle of the matching BVALID.

## Test plan
- Reset, then write 0xDEADBEEF to 0x04 with WSTRB=0xF, AW and W in the same cycle -> BVALID next cycle, BRESP=OKAY, wr_pulse[1] for 1 cycle; a read of 0x04 returns 0xDEADBEEF with OKAY.
- Write 0x11223344 to 0x08 with WSTRB=0x5 over register value 0xAAAAAAAA -> reg 2 = 0xAA22AA44.
- Present W three cycles before AW -> WREADY drops after the W handshake; BVALID one cycle after the AW handshake; data correct.
- Hold BREADY=0 for 5 cycles across two back-to-back writes -> second pair held, AWREADY/WREADY low, first BRESP stable; second BVALID the cycle after the first B handshake.
- With C_RO_MASK bit 3 set: write 0x0C -> SLVERR, reg 3 unchanged; reading 0x0C returns ro_in slice 3. With C_REGISTERS_NUMBER=16, write/read of 0x40 -> DECERR, RDATA=0.
- Assert reset with BVALID and RVALID pending -> both low next cycle, all registers 0; readies return to 1 after reset is released.

Source files
------------

// File: rtl/axi_4_lite_regbank.sv
// AXI4-Lite slave register bank with independent AW/W holds,
// read-only protection and decode errors on both channels.
module axi_4_lite_regbank #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 8,
    parameter int C_REGISTERS_NUMBER = 16,
    parameter logic [C_REGISTERS_NUMBER-1:0] C_RO_MASK = '0
) (
    input  logic S_AXI_ACLK,
    input  logic S_AXI_ARESET,
    input  logic S_AXI_AWVALID,
    output logic S_AXI_AWREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0] S_AXI_AWPROT,
    input  logic S_AXI_WVALID,
    output logic S_AXI_WREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    output logic S_AXI_BVALID,
    input  logic S_AXI_BREADY,
    output logic [1:0] S_AXI_BRESP,
    input  logic S_AXI_ARVALID,
    output logic S_AXI_ARREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0] S_AXI_ARPROT,
    output logic S_AXI_RVALID,
    input  logic S_AXI_RREADY,
    output logic [C_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0] S_AXI_RRESP,
    output logic [C_REGISTERS_NUMBER*C_AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [C_REGISTERS_NUMBER*C_AXI_DATA_WIDTH-1:0] ro_in,
    output logic [C_REGISTERS_NUMBER-1:0] wr_pulse
);
    localparam int W = C_AXI_DATA_WIDTH;
    localparam int AW = C_AXI_ADDR_WIDTH;
    localparam int NR = C_REGISTERS_NUMBER;
    localparam int SW = W / 8;
    localparam int ADDR_LSB = $clog2(SW);
    localparam int IDXW = AW - ADDR_LSB;

    logic aw_full, w_full;
    logic [AW-1:0] aw_addr_q;
    logic [W-1:0] w_data_q;
    logic [SW-1:0] w_strb_q;
    logic bvalid_q, rvalid_q;
    logic [1:0] bresp_q, rresp_q;
    logic [W-1:0] rdata_q;
    logic [NR*W-1:0] regs_q;
    logic [NR-1:0] wr_pulse_q;

    logic aw_hs, w_hs, ar_hs, aw_avail, w_avail, commit;
    logic [AW-1:0] wr_addr;
    logic [W-1:0] wr_data;
    logic [SW-1:0] wr_strb;
    logic [IDXW-1:0] w_idx, r_idx;
    logic [NR-1:0] w_hit, r_hit;
    logic w_dec, w_ro, r_dec, wr_ok;
    logic [W-1:0] rd_word;

    assign S_AXI_AWREADY = !aw_full && !S_AXI_ARESET;
    assign S_AXI_WREADY = !w_full && !S_AXI_ARESET;
    assign S_AXI_ARREADY = (!rvalid_q || S_AXI_RREADY) && !S_AXI_ARESET;
    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BRESP = bresp_q;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RDATA = rdata_q;
    assign S_AXI_RRESP = rresp_q;
    assign reg_out = regs_q;
    assign wr_pulse = wr_pulse_q;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
    assign aw_avail = aw_full || aw_hs;
    assign w_avail = w_full || w_hs;
    assign commit = aw_avail && w_avail && (!bvalid_q || S_AXI_BREADY);

    // A filled hold takes priority; otherwise the live channel feeds the commit.
    assign wr_addr = aw_full ? aw_addr_q : S_AXI_AWADDR;
    assign wr_data = w_full ? w_data_q : S_AXI_WDATA;
    assign wr_strb = w_full ? w_strb_q : S_AXI_WSTRB;
    assign w_idx = wr_addr[AW-1:ADDR_LSB];
    assign r_idx = S_AXI_ARADDR[AW-1:ADDR_LSB];

    always_comb begin
        w_hit = '0;
        r_hit = '0;
        rd_word = '0;
        for (int i = 0; i < NR; i++) begin
            w_hit[i] = (w_idx == IDXW'(i));
            r_hit[i] = (r_idx == IDXW'(i));
            if (r_hit[i])
                rd_word = C_RO_MASK[i] ? ro_in[i*W +: W] : regs_q[i*W +: W];
        end
    end

    assign w_dec = ~|w_hit;
    assign w_ro = |(w_hit & C_RO_MASK);
    assign r_dec = ~|r_hit;
    assign wr_ok = commit && !w_dec && !w_ro;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            aw_full <= 1'b0;
            w_full <= 1'b0;
            aw_addr_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bvalid_q <= 1'b0;
            bresp_q <= 2'b00;
            rvalid_q <= 1'b0;
            rresp_q <= 2'b00;
            rdata_q <= '0;
            regs_q <= '0;
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= '0;
            aw_full <= aw_avail && !commit;
            w_full <= w_avail && !commit;
            if (aw_hs) aw_addr_q <= S_AXI_AWADDR;
            if (w_hs) begin
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q <= w_dec ? 2'b11 : (w_ro ? 2'b10 : 2'b00);
            end else if (S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
            if (wr_ok) begin
                for (int i = 0; i < NR; i++)
                    for (int b = 0; b < SW; b++)
                        if (w_hit[i] && wr_strb[b])
                            regs_q[i*W + b*8 +: 8] <= wr_data[b*8 +: 8];
                if (|wr_strb) wr_pulse_q <= w_hit;
            end
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q <= r_dec ? '0 : rd_word;
                rresp_q <= r_dec ? 2'b11 : 2'b00;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, ro_in,
                         wr_addr[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};
endmodule
